// File: rtl/ddr_word_aligner.sv
// ddr_word_aligner: turns the two-bit-per-clock IDDR output into aligned
// parallel words. It hunts for a sync word at every bit offset, confirms it
// on several word boundaries, then streams words and watches sync recurrence.
module ddr_word_aligner #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD    = WIDTH'(8'hBC),
   parameter int unsigned      LOCK_CNT     = 4,
   parameter int unsigned      SYNC_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             resync,
   input  logic             ddr_q1,
   input  logic             ddr_q2,
   output logic [WIDTH-1:0] data,
   output logic             data_valid,
   output logic             data_is_sync,
   output logic             locked,
   output logic [7:0]       lock_loss_cnt
);

   localparam int unsigned SR_W     = 2 * WIDTH;
   localparam int unsigned HALF     = WIDTH / 2;
   localparam int unsigned PH_W     = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF - 1);
   localparam logic [7:0]      GOOD_TGT = 8'(LOCK_CNT);
   localparam logic [15:0]     TMO_TGT  = 16'(SYNC_TIMEOUT);

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_CHECK  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [SR_W-1:0]  sr;
   logic             bs, bs_nxt;
   logic [PH_W-1:0]  ph, ph_nxt;
   logic [7:0]       good_cnt, good_nxt, good_inc;
   logic [15:0]      tmo_cnt, tmo_nxt, tmo_inc;
   logic [7:0]       loss_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic             is_sync_nxt;

   logic [WIDTH-1:0] w0, w1, win;
   logic             win_is_sync;
   logic             boundary;
   logic             unused_sr_msbs;

   // Candidate windows: W0 is the newest WIDTH bits, W1 is the same shifted one bit older.
   assign w0          = sr[WIDTH-1:0];
   assign w1          = sr[WIDTH:1];
   assign win         = bs ? w1 : w0;
   assign win_is_sync = (win == SYNC_WORD);
   assign boundary    = en && (ph == PH_LAST);
   assign good_inc    = good_cnt + 8'd1;
   assign tmo_inc     = tmo_cnt + 16'd1;
   // The oldest two bits only ever fall off the end of the shift register.
   assign unused_sr_msbs = ^sr[SR_W-1:SR_W-2];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_HUNT;
      else     state <= state_nxt;
   end

   // Next-state, counter and output-word decisions.
   always_comb begin
      state_nxt   = state;
      bs_nxt      = bs;
      ph_nxt      = ph;
      good_nxt    = good_cnt;
      tmo_nxt     = tmo_cnt;
      loss_nxt    = lock_loss_cnt;
      data_nxt    = data;
      valid_nxt   = 1'b0;
      is_sync_nxt = data_is_sync;

      if (en) ph_nxt = (ph == PH_LAST) ? '0 : ph + PH_W'(1);

      case (state)
         S_HUNT: begin
            if (en) begin
               if (w0 == SYNC_WORD) begin
                  bs_nxt    = 1'b0;
                  ph_nxt    = '0;
                  good_nxt  = 8'd1;
                  state_nxt = S_CHECK;
               end else if (w1 == SYNC_WORD) begin
                  bs_nxt    = 1'b1;
                  ph_nxt    = '0;
                  good_nxt  = 8'd1;
                  state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (boundary) begin
               if (win_is_sync) begin
                  good_nxt = good_inc;
                  if (good_inc >= GOOD_TGT) begin
                     state_nxt = S_LOCKED;
                     tmo_nxt   = '0;
                  end
               end else begin
                  state_nxt = S_HUNT;
               end
            end
         end
         S_LOCKED: begin
            if (boundary) begin
               data_nxt    = win;
               valid_nxt   = 1'b1;
               is_sync_nxt = win_is_sync;
               if (win_is_sync) begin
                  tmo_nxt = '0;
               end else begin
                  tmo_nxt = tmo_inc;
                  if (tmo_inc >= TMO_TGT) state_nxt = S_HUNT;
               end
            end
         end
         default: state_nxt = S_HUNT;
      endcase

      if (resync) state_nxt = S_HUNT;

      if ((state == S_LOCKED) && (state_nxt == S_HUNT) && (lock_loss_cnt != 8'hFF))
         loss_nxt = lock_loss_cnt + 8'd1;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr            <= '0;
         bs            <= 1'b0;
         ph            <= '0;
         good_cnt      <= '0;
         tmo_cnt       <= '0;
         lock_loss_cnt <= '0;
         data          <= '0;
         data_valid    <= 1'b0;
         data_is_sync  <= 1'b0;
         locked        <= 1'b0;
      end else begin
         if (en) sr <= {sr[SR_W-3:0], ddr_q1, ddr_q2};
         bs            <= bs_nxt;
         ph            <= ph_nxt;
         good_cnt      <= good_nxt;
         tmo_cnt       <= tmo_nxt;
         lock_loss_cnt <= loss_nxt;
         data          <= data_nxt;
         data_valid    <= valid_nxt;
         data_is_sync  <= is_sync_nxt;
         locked        <= (state_nxt == S_LOCKED);
      end
   end

endmodule

// File: tb/tb_ddr_word_aligner.sv
// Bench for ddr_word_aligner: bit-stream reference model keyed on bit
// positions in the received stream, compared every cycle plus scenario checks.
module tb_ddr_word_aligner;

   localparam int unsigned W    = 8;
   localparam logic [7:0]  SYNC = 8'hBC;
   localparam int          LOCK = 4;
   localparam int          TO   = 16;

   logic       clk, rst, en, resync, ddr_q1, ddr_q2;
   logic [7:0] data;
   logic       data_valid, data_is_sync, locked;
   logic [7:0] lock_loss_cnt;

   ddr_word_aligner #(.WIDTH(W), .SYNC_WORD(SYNC), .LOCK_CNT(LOCK), .SYNC_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .en(en), .resync(resync), .ddr_q1(ddr_q1), .ddr_q2(ddr_q2),
      .data(data), .data_valid(data_valid), .data_is_sync(data_is_sync),
      .locked(locked), .lock_loss_cnt(lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit         pend[$];   // bits still to send, earliest first
   bit         hist[$];   // every bit sent since reset, earliest first
   logic [7:0] seen[$];   // words strobed out by the DUT

   // Reference model: mode 0 hunting, 1 confirming, 2 locked.
   int         m_mode, m_tgt, m_o, m_good, m_miss;
   logic [7:0] m_loss, m_data;
   logic       m_dv, m_sync, m_locked;

   // Word of W bits ending just before stream position e (MSB earliest).
   function automatic logic [7:0] word_at(input int e);
      logic [7:0] w;
      int idx;
      w = '0;
      for (int i = 0; i < int'(W); i++) begin
         idx = e - int'(W) + i;
         w = {w[6:0], (idx >= 0 && idx < hist.size()) ? hist[idx] : 1'b0};
      end
      return w;
   endfunction

   task automatic model_step(input bit e, input bit rs, input bit b1, input bit b2);
      int n, nxt;
      logic [7:0] w;
      n    = hist.size();
      nxt  = m_mode;
      m_dv = 1'b0;
      if (e) begin
         if (m_mode == 0) begin
            if (word_at(n) == SYNC) begin
               m_o = 0; m_tgt = n + int'(W); m_good = 1; nxt = 1;
            end else if (word_at(n - 1) == SYNC) begin
               m_o = 1; m_tgt = n + int'(W); m_good = 1; nxt = 1;
            end
         end else if (n == m_tgt) begin
            m_tgt = m_tgt + int'(W);
            w = word_at(n - m_o);
            if (m_mode == 1) begin
               if (w == SYNC) begin
                  m_good++;
                  if (m_good >= LOCK) begin nxt = 2; m_miss = 0; end
               end else nxt = 0;
            end else begin
               m_data = w; m_dv = 1'b1; m_sync = (w == SYNC);
               if (m_sync) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_miss >= TO) nxt = 0;
               end
            end
         end
         hist.push_back(b1);
         hist.push_back(b2);
      end
      if (rs) nxt = 0;
      if (m_mode == 2 && nxt == 0 && m_loss != 8'hFF) m_loss++;
      m_mode   = nxt;
      m_locked = (nxt == 2);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) pend.push_back(w[i]);
   endtask

   task automatic tick(input bit e, input bit rs);
      bit b1, b2;
      b1 = 1'b0; b2 = 1'b0;
      if (e && pend.size() != 0) b1 = pend.pop_front();
      if (e && pend.size() != 0) b2 = pend.pop_front();
      en = e; resync = rs; ddr_q1 = b1; ddr_q2 = b2;
      model_step(e, rs, b1, b2);
      @(posedge clk);
      #1;
      if (data_valid === 1'b1) seen.push_back(data);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; resync = 1'b0; ddr_q1 = 1'b0; ddr_q2 = 1'b0;
      pend.delete(); hist.delete(); seen.delete();
      m_mode = 0; m_tgt = 0; m_o = 0; m_good = 0; m_miss = 0;
      m_loss = '0; m_data = '0; m_dv = 1'b0; m_sync = 1'b0; m_locked = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (data !== 8'h00 || data_valid !== 1'b0 || data_is_sync !== 1'b0 || locked !== 1'b0 || lock_loss_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_state got data=%h dv=%b sync=%b lk=%b loss=%h required all zero", data, data_valid, data_is_sync, locked, lock_loss_cnt);
      end
   endtask

   task automatic test_aligned();
      int offs[5];
      logic [7:0] s0, s1;
      offs = '{0, 1, 3, 5, 7};
      foreach (offs[k]) begin
         do_reset();
         repeat (offs[k]) pend.push_back(1'b0);
         send_word(8'h00); send_word(8'h00);
         repeat (4) send_word(SYNC);
         send_word(8'hA5); send_word(SYNC); send_word(8'h00); send_word(8'h00);
         while (pend.size() != 0) begin
            tick(1'b1, 1'b0);
            total++;
            if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss || data !== m_data || (m_dv && data_is_sync !== m_sync)) begin
               bad++;
               $display("FAIL aligned_cycle off=%0d @%0t got dv=%b lk=%b loss=%0d data=%h sync=%b exp dv=%b lk=%b loss=%0d data=%h sync=%b", offs[k], $time, data_valid, locked, lock_loss_cnt, data, data_is_sync, m_dv, m_locked, m_loss, m_data, m_sync);
            end
         end
         s0 = (seen.size() > 0) ? seen[0] : 8'hxx;
         s1 = (seen.size() > 1) ? seen[1] : 8'hxx;
         total++;
         if (locked !== 1'b1 || s0 !== 8'hA5 || s1 !== SYNC) begin
            bad++;
            $display("FAIL aligned_words off=%0d got lk=%b words=%h,%h required lk=1 words=a5,bc", offs[k], locked, s0, s1);
         end
      end
   endtask

   task automatic test_check_fail();
      do_reset();
      send_word(8'h00); send_word(8'h00);
      repeat (3) send_word(SYNC);
      send_word(8'h00); send_word(8'h00);
      while (pend.size() != 0) begin
         tick(1'b1, 1'b0);
         total++;
         if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss || data !== m_data) begin
            bad++;
            $display("FAIL check_fail_cycle @%0t got dv=%b lk=%b loss=%0d exp dv=%b lk=%b loss=%0d", $time, data_valid, locked, lock_loss_cnt, m_dv, m_locked, m_loss);
         end
      end
      total++;
      if (locked !== 1'b0 || lock_loss_cnt !== 8'h00 || seen.size() != 0) begin
         bad++;
         $display("FAIL check_fail_state got lk=%b loss=%0d strobes=%0d required 0 0 0", locked, lock_loss_cnt, seen.size());
      end
      repeat (4) send_word(SYNC);
      send_word(8'h00); send_word(8'h00);
      while (pend.size() != 0) tick(1'b1, 1'b0);
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL check_relock got lk=%b required 1", locked);
      end
   endtask

   task automatic test_timeout();
      int n55;
      for (int run = 0; run < 2; run++) begin
         do_reset();
         send_word(8'h00);
         repeat (4) send_word(SYNC);
         repeat (15 + (1 - run)) send_word(8'h55);
         if (run == 1) begin send_word(SYNC); send_word(8'h55); end
         send_word(8'h00); send_word(8'h00);
         while (pend.size() != 0) begin
            tick(1'b1, 1'b0);
            total++;
            if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss || data !== m_data || (m_dv && data_is_sync !== m_sync)) begin
               bad++;
               $display("FAIL timeout_cycle run=%0d @%0t got dv=%b lk=%b loss=%0d data=%h exp dv=%b lk=%b loss=%0d data=%h", run, $time, data_valid, locked, lock_loss_cnt, data, m_dv, m_locked, m_loss, m_data);
            end
         end
         n55 = 0;
         foreach (seen[i]) if (seen[i] == 8'h55) n55++;
         total++;
         if (run == 0 && (n55 != 16 || locked !== 1'b0 || lock_loss_cnt !== 8'd1)) begin
            bad++;
            $display("FAIL timeout_drop got n55=%0d lk=%b loss=%0d required 16 0 1", n55, locked, lock_loss_cnt);
         end else if (run == 1 && (n55 != 16 || locked !== 1'b1 || lock_loss_cnt !== 8'd0)) begin
            bad++;
            $display("FAIL timeout_hold got n55=%0d lk=%b loss=%0d required 16 1 0", n55, locked, lock_loss_cnt);
         end
      end
   endtask

   task automatic test_resync_enable();
      logic [7:0] s0, s1, s2;
      do_reset();
      send_word(8'h00);
      repeat (4) send_word(SYNC);
      send_word(8'h00);
      while (pend.size() != 0) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      total++;
      if (locked !== 1'b0 || lock_loss_cnt !== 8'd1) begin
         bad++;
         $display("FAIL resync_drop got lk=%b loss=%0d required 0 1", locked, lock_loss_cnt);
      end
      seen.delete();
      send_word(8'h00);
      repeat (4) send_word(SYNC);
      send_word(8'hA5); send_word(SYNC); send_word(8'h3C); send_word(8'h00); send_word(8'h00);
      while (pend.size() != 0) begin
         if (pend.size() == 36) begin
            repeat (10) begin
               tick(1'b0, 1'b0);
               total++;
               if (data_valid !== 1'b0 || locked !== m_locked) begin
                  bad++;
                  $display("FAIL en_hold got dv=%b lk=%b required dv=0 lk=%b", data_valid, locked, m_locked);
               end
            end
         end
         tick(1'b1, 1'b0);
         total++;
         if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss || data !== m_data || (m_dv && data_is_sync !== m_sync)) begin
            bad++;
            $display("FAIL resync_cycle @%0t got dv=%b lk=%b loss=%0d data=%h exp dv=%b lk=%b loss=%0d data=%h", $time, data_valid, locked, lock_loss_cnt, data, m_dv, m_locked, m_loss, m_data);
         end
      end
      s0 = (seen.size() > 0) ? seen[0] : 8'hxx;
      s1 = (seen.size() > 1) ? seen[1] : 8'hxx;
      s2 = (seen.size() > 2) ? seen[2] : 8'hxx;
      total++;
      if (locked !== 1'b1 || s0 !== 8'hA5 || s1 !== SYNC || s2 !== 8'h3C) begin
         bad++;
         $display("FAIL en_resume got lk=%b words=%h,%h,%h required 1 a5,bc,3c", locked, s0, s1, s2);
      end
   endtask

   task automatic test_random();
      logic [7:0] w;
      bit e, rs;
      for (int run = 0; run < 4; run++) begin
         do_reset();
         repeat ($urandom_range(0, 7)) pend.push_back(1'b0);
         send_word(8'h00);
         repeat (4) send_word(SYNC);
         repeat (40) begin
            w = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
            send_word(w);
         end
         repeat (2) send_word(8'h00);
         while (pend.size() != 0) begin
            e  = ($urandom_range(0, 4) != 0);
            rs = ($urandom_range(0, 149) == 0);
            tick(e, rs);
            total++;
            if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss || data !== m_data || (m_dv && data_is_sync !== m_sync)) begin
               bad++;
               $display("FAIL random_cycle run=%0d @%0t got dv=%b lk=%b loss=%0d data=%h sync=%b exp dv=%b lk=%b loss=%0d data=%h sync=%b", run, $time, data_valid, locked, lock_loss_cnt, data, data_is_sync, m_dv, m_locked, m_loss, m_data, m_sync);
            end
         end
      end
   endtask

   task automatic test_reset_mid_and_saturate();
      do_reset();
      send_word(8'h00);
      repeat (4) send_word(SYNC);
      send_word(8'h00);
      while (pend.size() != 0) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      send_word(8'h00);
      repeat (4) send_word(SYNC);
      send_word(8'h00); send_word(8'hA5);
      while (pend.size() > 4) tick(1'b1, 1'b0);
      total++;
      if (locked !== 1'b1 || lock_loss_cnt !== 8'd1) begin
         bad++;
         $display("FAIL pre_reset got lk=%b loss=%0d required 1 1", locked, lock_loss_cnt);
      end
      rst = 1'b1;
      #1;
      total++;
      if (data !== 8'h00 || data_valid !== 1'b0 || data_is_sync !== 1'b0 || locked !== 1'b0 || lock_loss_cnt !== 8'h00) begin
         bad++;
         $display("FAIL async_reset got data=%h dv=%b sync=%b lk=%b loss=%h required all zero", data, data_valid, data_is_sync, locked, lock_loss_cnt);
      end
      do_reset();
      for (int ev = 0; ev < 256; ev++) begin
         send_word(8'h00);
         repeat (4) send_word(SYNC);
         send_word(8'h00);
         while (pend.size() != 0) begin
            tick(1'b1, 1'b0);
            total++;
            if (data_valid !== m_dv || locked !== m_locked || lock_loss_cnt !== m_loss) begin
               bad++;
               $display("FAIL sat_cycle ev=%0d got dv=%b lk=%b loss=%0d exp dv=%b lk=%b loss=%0d", ev, data_valid, locked, lock_loss_cnt, m_dv, m_locked, m_loss);
            end
         end
         tick(1'b1, 1'b1);
      end
      total++;
      if (lock_loss_cnt !== 8'hFF || locked !== 1'b0) begin
         bad++;
         $display("FAIL loss_saturate got loss=%h lk=%b required ff 0", lock_loss_cnt, locked);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; resync = 1'b0; ddr_q1 = 1'b0; ddr_q2 = 1'b0;
      test_reset();
      test_aligned();
      test_check_fail();
      test_timeout();
      test_resync_enable();
      test_random();
      test_reset_mid_and_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr_word_aligner.md
Name: ddr_word_aligner

Overview:
- Sequences the two-sample-per-clock output of an IDDR primitive (Q1 = rising-edge sample, Q2 = falling-edge sample) into aligned parallel words.
- Hunts for a sync word at every bit offset, confirms it over several word periods, then streams aligned words.
- Monitors sync recurrence and re-hunts when lock is lost.
- Sits between the IDDR input cell and the downstream FIFO/decoder of a serial readout channel.

Parameters:
- WIDTH, 8: word width in bits; must be even and at least 4.
- SYNC_WORD, 8'hBC: alignment pattern, WIDTH bits wide.
- LOCK_CNT, 4: number of consecutive on-boundary sync words that must be seen in CHECK before lock is declared (1..255).
- SYNC_TIMEOUT, 16: maximum number of words allowed in LOCKED without a sync word before lock is dropped (2..65535).

Ports:
- CLK  in  1  Sample clock; same clock as the IDDR C input.
- RST  in  1  Asynchronous, active-high reset.
- EN  in  1  Shift/processing enable.
- RESYNC  in  1  Single-cycle request to force HUNT.
- DDR_Q1  in  1  IDDR rising-edge sample; the earlier bit in time.
- DDR_Q2  in  1  IDDR falling-edge sample; the later bit in time.
- DATA  out  WIDTH  Aligned word; MSB is the earliest bit.
- DATA_VALID  out  1  One-cycle strobe marking a valid DATA.
- DATA_IS_SYNC  out  1  DATA equals SYNC_WORD; qualified by DATA_VALID.
- LOCKED  out  1  High while in the LOCKED state.
- LOCK_LOSS_CNT  out  8  Saturating count of LOCKED -> HUNT transitions.

Behaviour:
- Reset (asynchronous): all registers clear. State = HUNT. DATA = 0, DATA_VALID = 0, DATA_IS_SYNC = 0, LOCKED = 0, LOCK_LOSS_CNT = 0, shift register = 0.
- Shift register: SR is 2*WIDTH bits. When EN=1, SR <= {SR[2W-3:0], DDR_Q1, DDR_Q2}. When EN=0, SR and all counters hold and DATA_VALID = 0.
- Candidate windows: W0 = SR[WIDTH-1:0] and W1 = SR[WIDTH:1]. The bitslip register BS selects the active window.
- Phase counter PH runs 0..WIDTH/2-1 and wraps. A word boundary occurs when PH = WIDTH/2-1 and EN=1.
- HUNT: every EN cycle, test W0 then W1 against SYNC_WORD; W0 has priority if both match.
  - On a match: BS <= 0 or 1 to select the matching window, PH <= 0, good counter <= 1, next state = CHECK.
  - First boundary then falls exactly WIDTH/2 cycles after the match cycle.
  - No DATA_VALID is issued in HUNT.
- CHECK: at each boundary, compare the selected window with SYNC_WORD.
  - Match: good counter increments. When it reaches LOCK_CNT, next state = LOCKED and the timeout counter clears.
  - Mismatch: next state = HUNT, with no LOCK_LOSS_CNT increment.
  - If LOCK_CNT = 1, the state goes to LOCKED on the first boundary match.
  - No DATA_VALID is issued in CHECK.
- LOCKED: at each boundary, register DATA = selected window and assert DATA_VALID for one cycle (latency: 1 cycle after the boundary cycle). Set DATA_IS_SYNC when the window equals SYNC_WORD.
  - A sync word clears the timeout counter; any other word increments it.
  - If the counter reaches SYNC_TIMEOUT, next state = HUNT and LOCK_LOSS_CNT increments, saturating at 255.
  - The word that causes the timeout is still output with DATA_VALID.
- LOCKED output: LOCKED = (state == LOCKED), registered.
- RESYNC: forces HUNT on the next cycle from any state and takes priority over all other transitions.
  - From LOCKED, RESYNC increments LOCK_LOSS_CNT.
  - If RESYNC coincides with a boundary in LOCKED, that final word is still output.
- Reset mid-operation: immediate asynchronous clear with no completion of the current word. After RST deasserts, the block starts in HUNT.
- DATA keeps its last value between strobes.

Test Plan (WIDTH=8, SYNC_WORD=8'hBC, LOCK_CNT=4, SYNC_TIMEOUT=16):
1. Byte-aligned stream of 4 x 8'hBC then 8'hA5: BS=0 and LOCKED rises 1 cycle after the 4th sync boundary. A following 8'hA5, 8'hBC yields DATA_VALID strobes with DATA=8'hA5 (IS_SYNC=0), then DATA=8'hBC (IS_SYNC=1).
2. Same stream delayed by 1, 3, 5 and 7 bits: lock is reached in each case (BS=1 for odd offsets), and decoded data is identical to scenario 1.
3. 3 x 8'hBC then 8'h00 during CHECK: returns to HUNT, LOCKED stays 0, LOCK_LOSS_CNT=0. A subsequent 4 x 8'hBC still achieves lock.
4. After lock, send 16 consecutive non-sync words (8'h55): all 16 are output, then LOCKED falls and LOCK_LOSS_CNT=1. With 15 non-sync words followed by 8'hBC, lock holds.
5. RESYNC pulse while LOCKED: LOCKED=0 on the next cycle, LOCK_LOSS_CNT increments, relock occurs on the next 4 sync words. Hold EN=0 for 10 cycles mid-word: no strobes, and alignment is preserved on resume.
6. RST asserted mid-word while LOCKED: all outputs read 0 immediately without a clock edge. Drive 256 loss events: LOCK_LOSS_CNT saturates at 8'hFF.
